rvfi_trace_buffer: RTL
======================

# rvfi_trace_buffer

Retirement-trace capture stage downstream of the `riscv.Hart` RVFI port. Each retired instruction (`rvfi__valid` high) becomes a 4-word record in a small FIFO. The records are streamed out as 32-bit words over a valid/ready interface, for a debug UART or a trace sink. The block also flags dropped records and discontinuities in `rvfi__order`, so that hardware runs can be cross-checked against formal traces.

## Interface
- `DEPTH`, default 8: FIFO depth in records; power of two, ≥2.
- `clk`  in  1  clock; the only clock.
- `rst`  in  1  reset; synchronous, active-high.
- `rvfi__valid`  in  1  instruction retired this cycle.
- `rvfi__order`  in  64  retirement index.
- `rvfi__insn`  in  32  instruction word.
- `rvfi__trap`, `rvfi__halt`, `rvfi__intr`  in  1 each  RVFI flags.
- `rvfi__rd_addr`  in  5  destination register.
- `rvfi__rd_wdata`  in  32  destination write data.
- `rvfi__pc_rdata`  in  32  PC of the retired instruction.
- `out__valid`  out  1  `out__data` holds a trace word.
- `out__ready`  in  1  sink accepts the word.
- `out__data`  out  32  trace word.
- `out__last`  out  1  marks the final word (word 3) of a record.
- `overflow`  out  1  sticky; at least one record was dropped.
- `seq_err`  out  1  sticky; an order discontinuity was seen.
- `dropped`  out  16  count of dropped records; saturates at 0xFFFF.

## Operation
- Record word order:
  - word0 header: [31:16] `order[15:0]`, [15:11] `rd_addr`, [10] `trap`, [9] `halt`, [8] `intr`, [7] `gap`, [6:0] zero.
  - word1 `pc_rdata`.
  - word2 `insn`.
  - word3 `rd_wdata`.
- Capture: on a rising edge with `rvfi__valid`=1, the record is written if there is space. Space means FIFO not full, or the head record's word3 handshakes in the same cycle.
- Drop: if `rvfi__valid`=1 and there is no space:
  - the record is discarded;
  - `overflow` is set;
  - `dropped` increments (saturating);
  - `gap_pending` is set.
- Gap flag: the next accepted record carries `gap`=1 and clears `gap_pending`. All other records carry `gap`=0.
- Order check:
  - `expected` is a 64-bit register, reset to 0.
  - On every `rvfi__valid` (accepted or dropped), if `rvfi__order` ≠ `expected`, set `seq_err`.
  - Then `expected` ← `rvfi__order`+1, with 64-bit wrap.
- Serializer: two states, IDLE and SEND, plus a 2-bit word index `idx`.
  - IDLE → SEND when the FIFO is non-empty.
  - In SEND, `out__valid`=1 and `out__data` = the head record's word[`idx`].
  - On handshake (`out__valid & out__ready`), `idx` increments.
  - On handshake with `idx`=3: pop the head and set `idx`←0. Go to IDLE if the FIFO is now empty, otherwise stay in SEND.
- `out__last` = SEND & (`idx`=3).
- `out__data` and `out__last` stay stable while `out__valid & !out__ready`.
- FIFO pointers are log2(`DEPTH`)+1 bits and wrap naturally. Full = pointers differ only in MSB. Empty = pointers equal.

## Timing
- Reset values:
  - `out__valid`=0, `out__data`=0, `out__last`=0;
  - `overflow`=0, `seq_err`=0, `dropped`=0;
  - FIFO empty, `idx`=0, `expected`=0, `gap_pending`=0, state IDLE.
- Reset during a partially sent record discards that record. No `out__last` is emitted for it.
- Latency: a record captured at edge N gives `out__valid`=1 from cycle N+1, with word0.
- Throughput: with `out__ready` held high, one word per cycle, so a record every 4 cycles. Back-to-back retirements therefore overflow a DEPTH-record FIFO.
- Simultaneous push and final pop when full: both occur, and the FIFO stays full.
- Simultaneous push into an empty FIFO while IDLE: the word is presented the next cycle. There is no combinational path from `rvfi__*` to `out__*`.
- `overflow` and `seq_err` update at the edge where the event is sampled. They clear only on `rst`.
- `dropped` at 0xFFFF stays at 0xFFFF.

## Test plan
- Retire order 0, pc 0x0, insn 0x00000013, rd 0, wdata 0, with `out__ready`=1 → from the next cycle, out words are 0x00000000, 0x00000000, 0x00000013, 0x00000000; `out__last` on the 4th; `seq_err`=0.
- `out__ready`=0 with DEPTH=8, retire 9 consecutive orders 0..8 → `overflow`=1, `dropped`=1. Then release `out__ready` → 8 records are emitted (orders 0..7). Retire order 9 → its header has bit7=1 (`gap`).
- Retire orders 0, 1, 3 → `seq_err` rises at the edge sampling order 3. Records for 0, 1 and 3 are all emitted.
- Toggle `out__ready` every cycle during a record → each word is held stable until accepted; exactly 4 handshakes per record; `out__last` only on word3.
- FIFO full, `out__ready`=1 with `idx`=3, and `rvfi__valid`=1 in the same cycle → record accepted, `dropped` unchanged, FIFO still full.
- Assert `rst` after word1 of a record → next cycle all outputs are 0. The next retirement's record starts at word0 with `gap`=0.

Source files
------------

// File: rtl/rvfi_trace_buffer.sv
// RVFI retirement trace capture: each retired instruction becomes a 4-word record
// in a small FIFO, streamed out as 32-bit words with drop and order-gap tracking.
module rvfi_trace_buffer #(
  parameter int unsigned DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rvfi__valid,
  input  logic [63:0] rvfi__order,
  input  logic [31:0] rvfi__insn,
  input  logic        rvfi__trap,
  input  logic        rvfi__halt,
  input  logic        rvfi__intr,
  input  logic [4:0]  rvfi__rd_addr,
  input  logic [31:0] rvfi__rd_wdata,
  input  logic [31:0] rvfi__pc_rdata,
  output logic        out__valid,
  input  logic        out__ready,
  output logic [31:0] out__data,
  output logic        out__last,
  output logic        overflow,
  output logic        seq_err,
  output logic [15:0] dropped
);

  localparam int unsigned AW = $clog2(DEPTH);

  typedef enum logic {IDLE, SEND} state_t;
  typedef logic [3:0][31:0] rec_t;

  state_t              state_q, state_d;
  logic [1:0]          idx_q, idx_d;
  logic [AW:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  rec_t [DEPTH-1:0]    mem_q, mem_d;
  logic [63:0]         expected_q, expected_d;
  logic                overflow_q, overflow_d;
  logic                seq_err_q, seq_err_d;
  logic [15:0]         dropped_q, dropped_d;
  logic                gap_pending_q, gap_pending_d;

  logic        full, hs, pop, space, push;
  logic [31:0] header;

  assign full   = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign hs     = out__valid & out__ready;
  assign pop    = hs & (idx_q == 2'd3);
  // A record leaving this very edge frees its slot for the incoming one.
  assign space  = !full | pop;
  assign push   = rvfi__valid & space;
  assign header = {rvfi__order[15:0], rvfi__rd_addr, rvfi__trap, rvfi__halt, rvfi__intr,
                   gap_pending_q, 7'd0};

  always_comb begin
    mem_d         = mem_q;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    idx_d         = idx_q;
    expected_d    = expected_q;
    overflow_d    = overflow_q;
    seq_err_d     = seq_err_q;
    dropped_d     = dropped_q;
    gap_pending_d = gap_pending_q;

    if (rvfi__valid) begin
      if (rvfi__order != expected_q) seq_err_d = 1'b1;
      expected_d = rvfi__order + 64'd1;
      if (space) begin
        mem_d[wr_ptr_q[AW-1:0]] = {rvfi__rd_wdata, rvfi__insn, rvfi__pc_rdata, header};
        wr_ptr_d      = wr_ptr_q + 1'b1;
        gap_pending_d = 1'b0;
      end else begin
        overflow_d    = 1'b1;
        gap_pending_d = 1'b1;
        if (dropped_q != 16'hFFFF) dropped_d = dropped_q + 16'd1;
      end
    end

    if (hs) idx_d = idx_q + 2'd1;
    if (pop) rd_ptr_d = rd_ptr_q + 1'b1;

    // Looking at next-cycle occupancy lets a fresh record be presented one cycle after capture.
    state_d = (wr_ptr_d == rd_ptr_d) ? IDLE : SEND;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      idx_q         <= 2'd0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      expected_q    <= 64'd0;
      overflow_q    <= 1'b0;
      seq_err_q     <= 1'b0;
      dropped_q     <= 16'd0;
      gap_pending_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      expected_q    <= expected_d;
      overflow_q    <= overflow_d;
      seq_err_q     <= seq_err_d;
      dropped_q     <= dropped_d;
      gap_pending_q <= gap_pending_d;
    end
  end

  // Record storage needs no reset; only slots behind valid pointers are ever read out.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign out__valid = (state_q == SEND);
  assign out__data  = (state_q == SEND) ? mem_q[rd_ptr_q[AW-1:0]][idx_q] : 32'd0;
  assign out__last  = (state_q == SEND) && (idx_q == 2'd3);
  assign overflow   = overflow_q;
  assign seq_err    = seq_err_q;
  assign dropped    = dropped_q;

endmodule
